// File: rtl/ps2_key_ctrl.sv
// PS/2 receiver FIFO consumer: pops bytes, parses E0/F0 framing into make/break events,
// tracks the held key and counts new presses. Define PS2_EXT_KEY_EN to honour the E0 prefix.
module ps2_key_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             ready,
  input  logic [7:0]       data,
  input  logic             overflow,
  output logic             nextdata_n,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_down,
  output logic             key_make,
  output logic             key_break,
  output logic [CNT_W-1:0] press_count,
  output logic             ovf_seen
);

  // state | meaning
  // IDLE  | waiting for ready; samples and decodes the FIFO head byte
  // ACK   | pop strobe was driven low on entry; release it
  // GAP   | one idle cycle so the receiver can update ready/data
  typedef enum logic [1:0] {IDLE, ACK, GAP} state_t;

  localparam logic [7:0] B_EXT = 8'hE0;
  localparam logic [7:0] B_BRK = 8'hF0;

  state_t           state, state_nxt;
  logic             nextdata_n_nxt;
  logic [7:0]       key_code_nxt;
  logic             key_ext_nxt;
  logic             key_down_nxt;
  logic             key_make_nxt;
  logic             key_break_nxt;
  logic [CNT_W-1:0] press_count_nxt;
  logic             ovf_seen_nxt;
  logic             brk_pend, brk_pend_nxt;
  logic             ext_pend;
  logic             held_ext, held_ext_nxt;
  logic [7:0]       held_code, held_code_nxt;
  logic             is_discard;
  logic             is_ext_prefix;
  logic             held_match;

`ifdef PS2_EXT_KEY_EN
  logic ext_pend_nxt;
  assign is_ext_prefix = (data == B_EXT);
  assign is_discard    = (data == 8'hAA) || (data == 8'hFA) || (data == 8'h00);
`else
  // Without extended-key support E0 is just another ignored control byte.
  assign ext_pend      = 1'b0;
  assign is_ext_prefix = 1'b0;
  assign is_discard    = (data == 8'hAA) || (data == 8'hFA) || (data == 8'h00) ||
                         (data == B_EXT);
`endif

  assign held_match = ({ext_pend, data} == {held_ext, held_code});

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state       <= IDLE;
      nextdata_n  <= 1'b1;
      key_code    <= 8'h00;
      key_ext     <= 1'b0;
      key_down    <= 1'b0;
      key_make    <= 1'b0;
      key_break   <= 1'b0;
      press_count <= '0;
      ovf_seen    <= 1'b0;
      brk_pend    <= 1'b0;
      held_ext    <= 1'b0;
      held_code   <= 8'h00;
`ifdef PS2_EXT_KEY_EN
      ext_pend    <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      nextdata_n  <= nextdata_n_nxt;
      key_code    <= key_code_nxt;
      key_ext     <= key_ext_nxt;
      key_down    <= key_down_nxt;
      key_make    <= key_make_nxt;
      key_break   <= key_break_nxt;
      press_count <= press_count_nxt;
      ovf_seen    <= ovf_seen_nxt;
      brk_pend    <= brk_pend_nxt;
      held_ext    <= held_ext_nxt;
      held_code   <= held_code_nxt;
`ifdef PS2_EXT_KEY_EN
      ext_pend    <= ext_pend_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt       = state;
    nextdata_n_nxt  = 1'b1;
    key_code_nxt    = key_code;
    key_ext_nxt     = key_ext;
    key_down_nxt    = key_down;
    key_make_nxt    = 1'b0;
    key_break_nxt   = 1'b0;
    press_count_nxt = press_count;
    ovf_seen_nxt    = ovf_seen | overflow;
    brk_pend_nxt    = brk_pend;
    held_ext_nxt    = held_ext;
    held_code_nxt   = held_code;
`ifdef PS2_EXT_KEY_EN
    ext_pend_nxt    = ext_pend;
`endif

    case (state)
      IDLE: begin
        if (ready) begin
          nextdata_n_nxt = 1'b0;
          state_nxt      = ACK;
          if (is_ext_prefix) begin
`ifdef PS2_EXT_KEY_EN
            ext_pend_nxt = 1'b1;
`endif
          end else if (data == B_BRK) begin
            brk_pend_nxt = 1'b1;
          end else if (!is_discard) begin
            brk_pend_nxt = 1'b0;
`ifdef PS2_EXT_KEY_EN
            ext_pend_nxt = 1'b0;
`endif
            if (brk_pend) begin
              key_code_nxt  = data;
              key_ext_nxt   = ext_pend;
              key_break_nxt = 1'b1;
              // Releasing a key other than the held one leaves the held key down.
              if (held_match) key_down_nxt = 1'b0;
            end else if (!(key_down && held_match)) begin
              key_code_nxt    = data;
              key_ext_nxt     = ext_pend;
              held_ext_nxt    = ext_pend;
              held_code_nxt   = data;
              key_down_nxt    = 1'b1;
              key_make_nxt    = 1'b1;
              press_count_nxt = press_count + CNT_W'(1);
            end
          end
        end
      end
      ACK:     state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed self-checking bench for ps2_key_ctrl; follows PS2_EXT_KEY_EN for the E0 scenario.
module tb_ps2_key_ctrl;

  logic       clk = 1'b0;
  logic       clrn;
  logic       ready;
  logic [7:0] data;
  logic       overflow;
  logic       nextdata_n;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_down;
  logic       key_make;
  logic       key_break;
  logic [7:0] press_count;
  logic       ovf_seen;

  int checks = 0;
  int failures = 0;

`ifdef PS2_EXT_KEY_EN
  localparam logic EXP_EXT = 1'b1;
`else
  localparam logic EXP_EXT = 1'b0;
`endif

  ps2_key_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .clrn(clrn), .ready(ready), .data(data), .overflow(overflow),
    .nextdata_n(nextdata_n), .key_code(key_code), .key_ext(key_ext),
    .key_down(key_down), .key_make(key_make), .key_break(key_break),
    .press_count(press_count), .ovf_seen(ovf_seen)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    ready = 1'b0;
    overflow = 1'b0;
    clrn = 1'b0;
    @(negedge clk);
    clrn = 1'b1;
  endtask

  // Presents one byte, waits for the pop, and reports pulses in the pop cycle and the one after.
  task automatic send_byte(input logic [7:0] b, output logic mk, output logic bk,
                           output logic mk2, output logic bk2);
    bit ok = 0;
    @(negedge clk);
    ready = 1'b1;
    data = b;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!nextdata_n) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL pop_timeout byte=%h got=no_pop exp=pop", b);
    end
    mk = key_make;
    bk = key_break;
    ready = 1'b0;
    @(negedge clk);
    mk2 = key_make;
    bk2 = key_break;
  endtask

  task automatic test_reset();
    clrn = 1'b0; ready = 1'b0; data = 8'h00; overflow = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (nextdata_n !== 1'b1) begin failures++; $display("FAIL rst_nextdata_n got=%b exp=1", nextdata_n); end
    checks++; if (key_code !== 8'h00) begin failures++; $display("FAIL rst_key_code got=%h exp=00", key_code); end
    checks++; if ({key_ext, key_down, key_make, key_break, ovf_seen} !== 5'b0) begin
      failures++; $display("FAIL rst_flags got=%b exp=00000", {key_ext, key_down, key_make, key_break, ovf_seen}); end
    checks++; if (press_count !== 8'h00) begin failures++; $display("FAIL rst_count got=%h exp=00", press_count); end
    clrn = 1'b1;
  endtask

  task automatic test_make_break();
    logic mk, bk, mk2, bk2;
    do_reset();
    send_byte(8'h1C, mk, bk, mk2, bk2);
    checks++; if ({mk, bk, mk2, bk2} !== 4'b1000) begin failures++; $display("FAIL mb_make_pulse got=%b exp=1000", {mk, bk, mk2, bk2}); end
    checks++; if ({key_code, key_down, press_count} !== {8'h1C, 1'b1, 8'h01}) begin
      failures++; $display("FAIL mb_make_state got=%h/%b/%h exp=1c/1/01", key_code, key_down, press_count); end
    send_byte(8'hF0, mk, bk, mk2, bk2);
    checks++; if ({mk, bk, mk2, bk2} !== 4'b0000) begin failures++; $display("FAIL mb_prefix_pulse got=%b exp=0000", {mk, bk, mk2, bk2}); end
    send_byte(8'h1C, mk, bk, mk2, bk2);
    checks++; if ({mk, bk, mk2, bk2} !== 4'b0100) begin failures++; $display("FAIL mb_break_pulse got=%b exp=0100", {mk, bk, mk2, bk2}); end
    checks++; if ({key_code, key_down, press_count} !== {8'h1C, 1'b0, 8'h01}) begin
      failures++; $display("FAIL mb_break_state got=%h/%b/%h exp=1c/0/01", key_code, key_down, press_count); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [5] = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C};
    int idx = 0, pops = 0, makes = 0, breaks = 0, both = 0, consec = 0, close = 0;
    int last_pop = -10;
    bit prev_low = 0;
    do_reset();
    @(negedge clk);
    ready = 1'b1;
    data = seq[0];
    for (int cyc = 0; cyc < 60 && idx < 5; cyc++) begin
      @(negedge clk);
      if (key_make) makes++;
      if (key_break) breaks++;
      if (key_make && key_break) both++;
      if (!nextdata_n) begin
        if (prev_low) consec++;
        if (cyc - last_pop < 3) close++;
        last_pop = cyc;
        pops++;
        idx++;
        if (idx < 5) data = seq[idx];
        else ready = 1'b0;
      end
      prev_low = !nextdata_n;
    end
    repeat (3) @(negedge clk);
    checks++; if (pops != 5) begin failures++; $display("FAIL b2b_pops got=%0d exp=5", pops); end
    checks++; if (makes != 1 || breaks != 1 || both != 0) begin
      failures++; $display("FAIL b2b_pulses got=m%0d/b%0d/both%0d exp=m1/b1/both0", makes, breaks, both); end
    checks++; if (consec != 0 || close != 0) begin
      failures++; $display("FAIL b2b_spacing got=consec%0d/close%0d exp=0/0", consec, close); end
    checks++; if ({press_count, key_down} !== {8'h01, 1'b0}) begin
      failures++; $display("FAIL b2b_state got=%h/%b exp=01/0", press_count, key_down); end
  endtask

  task automatic test_ext();
    logic mk, bk, mk2, bk2;
    do_reset();
    send_byte(8'hE0, mk, bk, mk2, bk2);
    checks++; if ({mk, bk} !== 2'b00) begin failures++; $display("FAIL ext_e0_pulse got=%b exp=00", {mk, bk}); end
    send_byte(8'h75, mk, bk, mk2, bk2);
    checks++; if ({mk, bk, key_code, key_ext} !== {2'b10, 8'h75, EXP_EXT}) begin
      failures++; $display("FAIL ext_make got=%b%b/%h/%b exp=10/75/%b", mk, bk, key_code, key_ext, EXP_EXT); end
    send_byte(8'hE0, mk, bk, mk2, bk2);
    send_byte(8'hF0, mk, bk, mk2, bk2);
    send_byte(8'h75, mk, bk, mk2, bk2);
    checks++; if ({mk, bk, key_code, key_ext, key_down} !== {2'b01, 8'h75, EXP_EXT, 1'b0}) begin
      failures++; $display("FAIL ext_break got=%b%b/%h/%b/%b exp=01/75/%b/0", mk, bk, key_code, key_ext, key_down, EXP_EXT); end
  endtask

  task automatic test_rollover_discard();
    logic mk, bk, mk2, bk2;
    do_reset();
    send_byte(8'h1C, mk, bk, mk2, bk2);
    send_byte(8'h32, mk, bk, mk2, bk2);
    checks++; if ({mk, key_code, key_down, press_count} !== {1'b1, 8'h32, 1'b1, 8'h02}) begin
      failures++; $display("FAIL roll_make got=%b/%h/%b/%h exp=1/32/1/02", mk, key_code, key_down, press_count); end
    send_byte(8'hF0, mk, bk, mk2, bk2);
    send_byte(8'h1C, mk, bk, mk2, bk2);
    checks++; if ({bk, key_code, key_down} !== {1'b1, 8'h1C, 1'b1}) begin
      failures++; $display("FAIL roll_other_break got=%b/%h/%b exp=1/1c/1", bk, key_code, key_down); end
    send_byte(8'hF0, mk, bk, mk2, bk2);
    send_byte(8'hAA, mk, bk, mk2, bk2);
    checks++; if ({mk, bk} !== 2'b00) begin failures++; $display("FAIL discard_aa got=%b exp=00", {mk, bk}); end
    send_byte(8'hFA, mk, bk, mk2, bk2);
    send_byte(8'h00, mk, bk, mk2, bk2);
    send_byte(8'h32, mk, bk, mk2, bk2);
    checks++; if ({mk, bk, key_code, key_down, press_count} !== {2'b01, 8'h32, 1'b0, 8'h02}) begin
      failures++; $display("FAIL discard_keeps_brk got=%b%b/%h/%b/%h exp=01/32/0/02", mk, bk, key_code, key_down, press_count); end
  endtask

  task automatic test_wrap();
    logic mk, bk, mk2, bk2;
    logic [7:0] code;
    logic [7:0] exp_cnt;
    int errs = 0;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      code = 8'(i % 100 + 1);
      exp_cnt = 8'(i + 1);
      send_byte(code, mk, bk, mk2, bk2);
      if (!mk || mk2 || press_count !== exp_cnt) begin
        if (errs == 0) $display("FAIL wrap_make i=%0d got=%b/%h exp=1/%h", i, mk, press_count, exp_cnt);
        errs++;
      end
      send_byte(8'hF0, mk, bk, mk2, bk2);
      send_byte(code, mk, bk, mk2, bk2);
      if (!bk || bk2 || press_count !== exp_cnt || key_down !== 1'b0) begin
        if (errs == 0) $display("FAIL wrap_break i=%0d got=%b/%h/%b exp=1/%h/0", i, bk, press_count, key_down, exp_cnt);
        errs++;
      end
    end
    checks++; if (errs != 0) failures++;
    checks++; if (press_count !== 8'h00) begin failures++; $display("FAIL wrap_final got=%h exp=00", press_count); end
  endtask

  task automatic test_overflow();
    logic mk, bk, mk2, bk2;
    do_reset();
    @(negedge clk); overflow = 1'b1;
    @(negedge clk); overflow = 1'b0;
    checks++; if (ovf_seen !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", ovf_seen); end
    send_byte(8'h1C, mk, bk, mk2, bk2);
    checks++; if ({mk, ovf_seen, press_count} !== {1'b1, 1'b1, 8'h01}) begin
      failures++; $display("FAIL ovf_continue got=%b/%b/%h exp=1/1/01", mk, ovf_seen, press_count); end
    @(negedge clk); clrn = 1'b0; #1;
    checks++; if (ovf_seen !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", ovf_seen); end
    @(negedge clk); clrn = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic mk, bk, mk2, bk2;
    bit ok = 0;
    do_reset();
    send_byte(8'h1C, mk, bk, mk2, bk2);
    @(negedge clk);
    ready = 1'b1; data = 8'hF0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!nextdata_n) begin ok = 1; break; end
    end
    checks++; if (!ok) begin failures++; $display("FAIL mid_pop got=no_pop exp=pop"); end
    ready = 1'b0;
    clrn = 1'b0;
    #1;
    checks++; if ({nextdata_n, key_code, key_down, press_count, key_make, key_break} !== {1'b1, 8'h00, 1'b0, 8'h00, 2'b00}) begin
      failures++; $display("FAIL mid_reset got=%b/%h/%b/%h/%b%b exp=1/00/0/00/00",
                           nextdata_n, key_code, key_down, press_count, key_make, key_break); end
    @(negedge clk); clrn = 1'b1;
    send_byte(8'h1C, mk, bk, mk2, bk2);
    checks++; if ({mk, bk, key_down, press_count} !== {2'b10, 1'b1, 8'h01}) begin
      failures++; $display("FAIL mid_after got=%b%b/%b/%h exp=10/1/01", mk, bk, key_down, press_count); end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_back_to_back();
    test_ext();
    test_rollover_discard();
    test_wrap();
    test_overflow();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_key_ctrl.md
# ps2_key_ctrl

Consumer-side controller for the PS/2 keyboard receiver FIFO. Pops bytes over the `ready`/`nextdata_n` handshake, parses scan-code framing (E0 extended prefix, F0 break prefix) into key make/break events, tracks the currently held key, and counts distinct key presses. Sits between `ps2_keyboard` and the display/ASCII logic, replacing ad-hoc pop logic in the top level.

## Interface
- `CNT_W`, 8, width of the press counter

- `clk`  in  1  system clock; all state changes on rising edge
- `clrn`  in  1  asynchronous active-low reset
- `ready`  in  1  receiver FIFO non-empty; `data` valid while high
- `data`  in  8  FIFO head byte
- `overflow`  in  1  receiver FIFO overflow flag
- `nextdata_n`  out  1  active-low pop strobe to receiver
- `key_code`  out  8  scan code of last make/break event (without prefixes)
- `key_ext`  out  1  last event carried E0 prefix
- `key_down`  out  1  a key is currently held
- `key_make`  out  1  one-cycle pulse: new (non-repeat) key press
- `key_break`  out  1  one-cycle pulse: key release
- `press_count`  out  CNT_W  number of new presses, modulo 2^CNT_W
- `ovf_seen`  out  1  sticky: `overflow` was observed high

## Operation
- FSM states: IDLE, ACK, GAP.
  - IDLE: if `ready`=1, sample `data`, decode, update outputs, drive `nextdata_n`<=0, go ACK; else stay.
  - ACK: `nextdata_n`<=1, go GAP.
  - GAP: go IDLE (lets receiver update `ready`/`data` after the pop).
- Internal flags `brk_pend`, `ext_pend`, held-key register `{held_ext, held_code}`.
- Decode of sampled byte b:
  - b=0xE0: `ext_pend`<=1; no event.
  - b=0xF0: `brk_pend`<=1; no event.
  - b=0xAA, 0xFA, 0x00: discarded; flags unchanged.
  - other b with `brk_pend`=1: break event: `key_code`<=b, `key_ext`<=`ext_pend`, `key_break` pulses; if {ext_pend,b} equals held key, `key_down`<=0, else `key_down` unchanged. Clear both flags.
  - other b with `brk_pend`=0: if `key_down`=1 and {ext_pend,b} equals held key → typematic repeat: no pulse, no count. Otherwise make event: `key_code`<=b, `key_ext`<=`ext_pend`, held key<={ext_pend,b}, `key_down`<=1, `key_make` pulses, `press_count`+1 (wraps all-ones→0). Clear both flags.
- New key pressed while another held: treated as make; held key replaced.
- `ovf_seen` set on any cycle `overflow`=1; cleared only by reset. Popping continues regardless.

## Timing
- Reset (async, immediate): state IDLE, `nextdata_n`=1, `key_code`=0, `key_ext`=0, `key_down`=0, `key_make`=0, `key_break`=0, `press_count`=0, `ovf_seen`=0, flags and held key 0.
- All outputs registered. Byte sampled at edge N (IDLE, `ready`=1): event outputs and pulses valid after edge N, `nextdata_n` low for exactly cycle N..N+1, back in IDLE after edge N+2; next byte sampled at earliest edge N+3. Max throughput one byte per 3 clocks.
- `key_make`/`key_break` high exactly one cycle; never both.
- `nextdata_n` never low for two consecutive cycles and never low when popped byte was not sampled.
- Reset asserted mid-sequence (ACK/GAP, prefix pending): pending prefix lost, no pulse emitted; at most one FIFO byte consumed.

## Configuration
- `PS2_EXT_KEY_EN` defined: E0 prefix handled as above; `key_ext` and held-key match include the extended bit.
- Not defined: 0xE0 is discarded like 0xAA; `ext_pend` absent; `key_ext` tied 0; E0-prefixed keys alias their base codes.

## Test plan
- Reset, then FIFO bytes 1C, F0, 1C → one `key_make` (code 1C, `key_down`=1, count 1), then one `key_break` (code 1C, `key_down`=0); count stays 1.
- Bytes 1C,1C,1C,F0,1C (typematic) → single `key_make`, single `key_break`, count 1; five pops, each `nextdata_n` pulse one cycle wide, spaced ≥3 cycles.
- With `PS2_EXT_KEY_EN`: E0,75,E0,F0,75 → make code 75 `key_ext`=1, break code 75 `key_ext`=1; without macro: same stream → make 75, break 75, `key_ext`=0.
- CNT_W=8, 256 distinct make/break pairs → `press_count` returns to 0x00, no glitch on wrap.
- Pulse `overflow` one cycle → `ovf_seen`=1 until `clrn` low; decoding continues.
- Assert `clrn` low during ACK after an F0 → all outputs reset immediately; subsequent byte 1C decoded as make, not break.
